// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) helpers, MixColumns constants and round-core FSM encoding
package aes_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, DONE = 2'd2} state_e;
  localparam logic [7:0] GF_02 = 8'h02;
  localparam logic [7:0] GF_03 = 8'h03;
  localparam logic [7:0] GF_09 = 8'h09;
  localparam logic [7:0] GF_0B = 8'h0B;
  localparam logic [7:0] GF_0D = 8'h0D;
  localparam logic [7:0] GF_0E = 8'h0E;
  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction
  // constant c folds the xtime chain down to a few XOR taps
  function automatic logic [7:0] gf_mul(logic [7:0] b, logic [7:0] c);
    logic [7:0] p, x;
    p = '0;
    x = b;
    for (int i = 0; i < 8; i++) begin
      p = c[3'(i)] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] mix_row(logic [7:0] a0, logic [7:0] a1, logic [7:0] a2,
                                         logic [7:0] a3, logic inv);
    return inv ? gf_mul(a0, GF_0E) ^ gf_mul(a1, GF_0B) ^ gf_mul(a2, GF_0D) ^ gf_mul(a3, GF_09)
               : gf_mul(a0, GF_02) ^ gf_mul(a1, GF_03) ^ a2 ^ a3;
  endfunction
  function automatic logic [31:0] col_get(logic [127:0] s, logic [1:0] c);
    return s[{c, 5'd0} +: 32];
  endfunction
endpackage

// File: rtl/mix_col_word.sv
// mix_col_word: combinational MixColumns / InvMixColumns of one 32-bit column
module mix_col_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);
  logic [7:0] b0, b1, b2, b3;
  assign {b0, b1, b2, b3} = col_i;
  assign col_o = {mix_row(b0, b1, b2, b3, inv_i), mix_row(b1, b2, b3, b0, inv_i),
                  mix_row(b2, b3, b0, b1, inv_i), mix_row(b3, b0, b1, b2, inv_i)};
endmodule

// File: rtl/mix_col_iter.sv
// mix_col_iter: iterative AES (Inv)MixColumns engine, COLS_PER_CYCLE columns per clock
module mix_col_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  input  logic         in_enable,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NUM_BEATS = 4 / COLS_PER_CYCLE;
  localparam int BW = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NUM_BEATS - 1);
  state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [127:0] data_q, data_d, res_q, res_d, res_nx;
  logic inv_q, inv_d;
  logic [31:0] col_out [COLS_PER_CYCLE];
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad
    $error("mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_word
    mix_col_word u_word (
      .col_i(col_get(data_q, 2'(int'(beat_q) * COLS_PER_CYCLE + g))),
      .inv_i(inv_q),
      .col_o(col_out[g])
    );
  end
  // column c belongs to beat c/CPC and is produced by word unit c%CPC
  for (genvar c = 0; c < 4; c++) begin : g_res
    assign res_nx[32*c +: 32] = (BW'(c / COLS_PER_CYCLE) == beat_q) ? col_out[c % COLS_PER_CYCLE]
                                                                    : res_q[32*c +: 32];
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = res_q;
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    inv_d   = inv_q;
    res_d   = res_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        data_d  = in_data;
        inv_d   = in_inv;
        beat_d  = '0;
        res_d   = in_enable ? res_q : in_data;
        state_d = in_enable ? COMPUTE : DONE;
      end
    end else if (state_q == COMPUTE) begin
      res_d   = res_nx;
      beat_d  = (beat_q == LAST) ? '0 : beat_q + BW'(1);
      state_d = (beat_q == LAST) ? DONE : COMPUTE;
    end else if (out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      res_q   <= res_d;
    end
  end
endmodule
